// File: rtl/operand_fetch_stage_if.sv
// Operand-fetch stage bundle: decoded instruction in, register-file select/data,
// MEM/WB forwarding sources, flush, and the valid/ready latch towards execute.
//   slave  : view of the operand_fetch_stage itself
//   master : view of the surrounding pipeline (decode, register file, MEM, WB, EX)
interface operand_fetch_stage_if #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs;
  logic [REG_AW-1:0] in_rt;
  logic              in_use1;
  logic              in_use2;
  logic [REG_AW-1:0] in_rd;
  logic [CTRL_W-1:0] in_ctrl;
  logic [REG_AW-1:0] rsel1;
  logic [REG_AW-1:0] rsel2;
  logic [WORD_W-1:0] rdat1;
  logic [WORD_W-1:0] rdat2;
  logic              mem_wen;
  logic              mem_load;
  logic [REG_AW-1:0] mem_wsel;
  logic [WORD_W-1:0] mem_wdat;
  logic              wb_wen;
  logic [REG_AW-1:0] wb_wsel;
  logic [WORD_W-1:0] wb_wdat;
  logic              flush;
  logic              out_valid;
  logic              ex_ready;
  logic [WORD_W-1:0] out_opa;
  logic [WORD_W-1:0] out_opb;
  logic [REG_AW-1:0] out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  in_valid, in_rs, in_rt, in_use1, in_use2, in_rd, in_ctrl,
    input  rdat1, rdat2,
    input  mem_wen, mem_load, mem_wsel, mem_wdat,
    input  wb_wen, wb_wsel, wb_wdat,
    input  flush, ex_ready,
    output in_ready, rsel1, rsel2,
    output out_valid, out_opa, out_opb, out_rd, out_ctrl, stall_cnt
  );

  modport master (
    output in_valid, in_rs, in_rt, in_use1, in_use2, in_rd, in_ctrl,
    output rdat1, rdat2,
    output mem_wen, mem_load, mem_wsel, mem_wdat,
    output wb_wen, wb_wsel, wb_wdat,
    output flush, ex_ready,
    input  in_ready, rsel1, rsel2,
    input  out_valid, out_opa, out_opb, out_rd, out_ctrl, stall_cnt
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage. Drives register-file read selects straight from the
// decoded instruction, merges read data with MEM/WB forwards, holds the
// instruction back on a load-use hazard, and registers the operands into a
// single valid/ready latch feeding execute.
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous reset, active low
//   bus  - operand_fetch_stage_if.slave (instruction in, regfile, forwards,
//          flush, execute handshake, stall counter)
module operand_fetch_stage #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  operand_fetch_stage_if.slave  bus
);

  logic [REG_AW-1:0] src_sel  [2];
  logic              src_use  [2];
  logic [WORD_W-1:0] src_rdat [2];
  logic [WORD_W-1:0] src_fwd  [2];
  logic              src_haz  [2];

  logic              hazard;
  logic              ready;

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] opa_q,   opa_d;
  logic [WORD_W-1:0] opb_q,   opb_d;
  logic [REG_AW-1:0] rd_q,    rd_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  assign src_sel[0]  = bus.in_rs;
  assign src_sel[1]  = bus.in_rt;
  assign src_use[0]  = bus.in_use1;
  assign src_use[1]  = bus.in_use2;
  assign src_rdat[0] = bus.rdat1;
  assign src_rdat[1] = bus.rdat2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // MEM is younger than WB, so it is checked first. A MEM load has no data
      // yet and must not be forwarded; the hazard logic covers that case.
      assign src_fwd[gi] =
        (src_sel[gi] == '0) ? '0 :
        (bus.mem_wen && !bus.mem_load && bus.mem_wsel == src_sel[gi]) ? bus.mem_wdat :
        (bus.wb_wen && bus.wb_wsel == src_sel[gi]) ? bus.wb_wdat :
        src_rdat[gi];

      assign src_haz[gi] = src_use[gi] && (src_sel[gi] != '0) &&
                           bus.mem_wen && bus.mem_load &&
                           (bus.mem_wsel == src_sel[gi]);
    end
  endgenerate

  assign hazard = bus.in_valid && (src_haz[0] || src_haz[1]);
  // Flush always accepts so the squashed instruction drains from decode.
  assign ready  = bus.flush || (!hazard && (!valid_q || bus.ex_ready));

  assign bus.rsel1     = bus.in_rs;
  assign bus.rsel2     = bus.in_rt;
  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_opa   = opa_q;
  assign bus.out_opb   = opb_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_ctrl  = ctrl_q;
  assign bus.stall_cnt = cnt_q;

  always_comb begin
    valid_d = valid_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;

    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (bus.in_valid && ready) begin
      valid_d = 1'b1;
      opa_d   = src_fwd[0];
      opb_d   = src_fwd[1];
      rd_d    = bus.in_rd;
      ctrl_d  = bus.in_ctrl;
    end else if (bus.ex_ready) begin
      valid_d = 1'b0;
    end

    // Saturating: a stuck counter is more useful than one that wrapped to 0.
    if (hazard && !bus.flush && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus a random stream,
// a scoreboard of expected latch contents, and a small-counter instance for
// saturation.
module tb_operand_fetch_stage;

  logic CLK;
  logic nRST;

  operand_fetch_stage_if #(.WORD_W(32), .REG_AW(5), .CTRL_W(16), .CNT_W(16)) bus ();
  operand_fetch_stage_if #(.WORD_W(32), .REG_AW(5), .CTRL_W(16), .CNT_W(2))  bus2 ();

  operand_fetch_stage #(.WORD_W(32), .REG_AW(5), .CTRL_W(16), .CNT_W(16)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  operand_fetch_stage #(.WORD_W(32), .REG_AW(5), .CTRL_W(16), .CNT_W(2)) dut2 (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  rd;
    logic [15:0] ctrl;
  } exp_t;

  exp_t sb[$];
  logic mvalid;
  int   mcnt;
  int   n_checks;
  int   n_pass;
  int   n_txn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] fwd_m(input logic [4:0] s, input logic [31:0] rdat);
    if (s == 5'd0) return 32'd0;
    if (bus.mem_wen && !bus.mem_load && bus.mem_wsel == s) return bus.mem_wdat;
    if (bus.wb_wen && bus.wb_wsel == s) return bus.wb_wdat;
    return rdat;
  endfunction

  function automatic logic haz_m(input logic [4:0] s);
    return (s != 5'd0) && bus.mem_wen && bus.mem_load && (bus.mem_wsel == s);
  endfunction

  task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic [15:0] ctrl, input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid = v;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_use1  = u1;
    bus.in_use2  = u2;
    bus.in_rd    = rd;
    bus.in_ctrl  = ctrl;
    bus.rdat1    = r1;
    bus.rdat2    = r2;
  endtask

  task automatic set_fwd(input logic mw, input logic ml, input logic [4:0] msel,
                         input logic [31:0] mdat, input logic ww, input logic [4:0] wsel,
                         input logic [31:0] wdat);
    bus.mem_wen  = mw;
    bus.mem_load = ml;
    bus.mem_wsel = msel;
    bus.mem_wdat = mdat;
    bus.wb_wen   = ww;
    bus.wb_wsel  = wsel;
    bus.wb_wdat  = wdat;
  endtask

  // One clock: check combinational outputs and latch contents before the edge,
  // advance the model, then check registered state just after the edge.
  task automatic cycle();
    logic exp_haz;
    logic exp_rdy;
    exp_t e;
    @(negedge CLK);
    exp_haz = bus.in_valid && ((bus.in_use1 && haz_m(bus.in_rs)) ||
                               (bus.in_use2 && haz_m(bus.in_rt)));
    exp_rdy = bus.flush || (!exp_haz && (!mvalid || bus.ex_ready));
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    chk("rsel1", {27'd0, bus.rsel1}, {27'd0, bus.in_rs});
    chk("rsel2", {27'd0, bus.rsel2}, {27'd0, bus.in_rt});
    if (mvalid) begin
      if (sb.size() == 0) begin
        chk("sb_size", 32'(sb.size()), 32'd1);
      end else begin
        e = sb[0];
        chk("out_opa", bus.out_opa, e.opa);
        chk("out_opb", bus.out_opb, e.opb);
        chk("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
        chk("out_ctrl", {16'd0, bus.out_ctrl}, {16'd0, e.ctrl});
        if (bus.ex_ready) begin
          n_txn++;
          $display("txn %0d: opa=0x%0h opb=0x%0h rd=%0d ctrl=0x%0h", n_txn,
                   bus.out_opa, bus.out_opb, bus.out_rd, bus.out_ctrl);
        end
        if (bus.ex_ready || bus.flush) void'(sb.pop_front());
      end
    end
    if (exp_haz && !bus.flush && mcnt != 65535) mcnt++;
    if (bus.flush) begin
      mvalid = 1'b0;
    end else if (bus.in_valid && exp_rdy) begin
      sb.push_back('{fwd_m(bus.in_rs, bus.rdat1), fwd_m(bus.in_rt, bus.rdat2),
                     bus.in_rd, bus.in_ctrl});
      mvalid = 1'b1;
    end else if (bus.ex_ready) begin
      mvalid = 1'b0;
    end
    @(posedge CLK);
    #1;
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mvalid});
    chk("stall_cnt", {16'd0, bus.stall_cnt}, 32'(mcnt));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_txn    = 0;
    mvalid   = 1'b0;
    mcnt     = 0;
    nRST     = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_rs = '0; bus2.in_rt = '0; bus2.in_use1 = 1'b0;
    bus2.in_use2 = 1'b0; bus2.in_rd = '0; bus2.in_ctrl = '0; bus2.rdat1 = '0;
    bus2.rdat2 = '0; bus2.mem_wen = 1'b0; bus2.mem_load = 1'b0; bus2.mem_wsel = '0;
    bus2.mem_wdat = '0; bus2.wb_wen = 1'b0; bus2.wb_wsel = '0; bus2.wb_wdat = '0;
    bus2.flush = 1'b0; bus2.ex_ready = 1'b0;

    // Reset state
    @(posedge CLK); @(posedge CLK); #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_opa", bus.out_opa, 32'd0);
    chk("rst_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // WB bypass beats stale register-file data
    bus.ex_ready = 1'b1;
    set_fwd(0, 0, 0, 0, 1, 3, 32'hAA);
    set_in(1, 3, 0, 1, 0, 9, 16'h1234, 32'h11, 32'h0);
    cycle();
    // MEM wins over WB on the same index; index 0 forces zero
    set_fwd(1, 0, 5, 32'h55, 1, 5, 32'h66);
    set_in(1, 1, 5, 1, 1, 4, 16'h0005, 32'h77, 32'h99);
    cycle();
    set_in(1, 5, 0, 1, 1, 6, 16'h0006, 32'h88, 32'h99);
    cycle();

    // Load-use: two hazard cycles, bubble drains, then accept
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    set_in(1, 2, 0, 1, 0, 2, 16'h0002, 32'h22, 32'h0);
    cycle();
    set_fwd(1, 1, 7, 32'hDEAD, 0, 0, 0);
    set_in(1, 7, 1, 1, 0, 3, 16'h0003, 32'h70, 32'h10);
    cycle();
    cycle();
    set_fwd(1, 1, 7, 32'hDEAD, 0, 0, 0);
    set_in(1, 7, 1, 0, 0, 3, 16'h0013, 32'h70, 32'h10);
    cycle();
    set_fwd(1, 1, 0, 32'hBEEF, 0, 0, 0);
    set_in(1, 0, 0, 1, 1, 8, 16'h0008, 32'h5, 32'h6);
    cycle();
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    set_in(1, 7, 2, 1, 1, 3, 16'h0023, 32'h70, 32'h20);
    cycle();

    // Backpressure: A held for three cycles while B waits
    set_in(1, 1, 0, 1, 0, 10, 16'h00A0, 32'h1, 32'h0);
    cycle();
    bus.ex_ready = 1'b0;
    set_in(1, 1, 2, 1, 1, 11, 16'h00B0, 32'hB, 32'hB2);
    cycle(); cycle(); cycle();
    bus.ex_ready = 1'b1;
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Flush squashes the latch and swallows the incoming instruction
    set_in(1, 4, 0, 1, 0, 12, 16'h00C0, 32'h44, 32'h0);
    cycle();
    bus.ex_ready = 1'b0;
    bus.flush    = 1'b1;
    set_in(1, 4, 0, 1, 0, 13, 16'h00D0, 32'h45, 32'h0);
    cycle();
    // Flush during a hazard: no stall counted
    set_fwd(1, 1, 4, 32'h0, 0, 0, 0);
    cycle();
    bus.flush = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    bus.ex_ready = 1'b1;

    // Asynchronous reset mid-stream
    set_in(1, 6, 0, 1, 0, 14, 16'h00E0, 32'h66, 32'h0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 nRST = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_opa", bus.out_opa, 32'd0);
    chk("arst_ctrl", {16'd0, bus.out_ctrl}, 32'd0);
    chk("arst_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    mvalid = 1'b0;
    sb.delete();
    mcnt = 0;
    @(negedge CLK);
    nRST = 1'b1;
    cycle();

    // Random stream with overlapping indices to exercise every priority
    for (int i = 0; i < 60; i++) begin
      set_in($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             16'($urandom), $urandom, $urandom);
      set_fwd(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 5'($urandom_range(0, 3)),
              $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      bus.ex_ready = $urandom_range(0, 3) != 0;
      bus.flush    = $urandom_range(0, 9) == 0;
      cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    cycle();
    cycle();

    // Saturation on a 2-bit counter over five hazard cycles
    bus2.in_valid = 1'b1; bus2.in_rs = 5'd7; bus2.in_use1 = 1'b1;
    bus2.mem_wen = 1'b1; bus2.mem_load = 1'b1; bus2.mem_wsel = 5'd7;
    for (int k = 1; k <= 5; k++) begin
      @(posedge CLK); #1;
      chk("sat_cnt", {30'd0, bus2.stall_cnt}, (k < 3) ? 32'(k) : 32'd3);
      chk("sat_ready", {31'd0, bus2.in_ready}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-side operand stage that sits directly downstream of the register file in the pipelined processor.
- Drives the register-file read selects from the decoded instruction and merges the read data with forwarded MEM and WB results. The WB bypass is needed because register-file writes only land at the clock edge.
- Detects load-use hazards and registers operands into a valid/ready pipeline latch that feeds the execute stage.

Parameters:
- WORD_W, 32, data word width.
- REG_AW, 5, register index width (2**REG_AW registers; index 0 hardwired zero).
- CTRL_W, 16, width of opaque control bundle carried to execute.
- CNT_W, 16, width of saturating hazard-stall counter.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous reset, active low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- in_rs  in  REG_AW  source register 1 index.
- in_rt  in  REG_AW  source register 2 index.
- in_use1  in  1  instruction reads rs.
- in_use2  in  1  instruction reads rt.
- in_rd  in  REG_AW  destination index, passed through.
- in_ctrl  in  CTRL_W  control bundle, passed through.
- rsel1  out  REG_AW  register-file read select 1.
- rsel2  out  REG_AW  register-file read select 2.
- rdat1  in  WORD_W  register-file read data 1.
- rdat2  in  WORD_W  register-file read data 2.
- mem_wen  in  1  MEM-stage instruction will write a register.
- mem_load  in  1  MEM-stage instruction is a load; its data is not yet available.
- mem_wsel  in  REG_AW  MEM-stage destination.
- mem_wdat  in  WORD_W  MEM-stage ALU result.
- wb_wen  in  1  writeback enable, same signal the register file receives.
- wb_wsel  in  REG_AW  writeback destination.
- wb_wdat  in  WORD_W  writeback data.
- flush  in  1  squash (branch/jump redirect).
- out_valid  out  1  operands valid to execute.
- ex_ready  in  1  execute consumes the latch this cycle.
- out_opa  out  WORD_W  operand A.
- out_opb  out  WORD_W  operand B.
- out_rd  out  REG_AW  registered in_rd.
- out_ctrl  out  CTRL_W  registered in_ctrl.
- stall_cnt  out  CNT_W  cycles stalled on load-use hazard.

Behaviour:
- Read selects are combinational: rsel1 = in_rs, rsel2 = in_rt. No registering.
- Operand select, evaluated per source s with index sel (first match wins):
  1. sel == 0 gives 0.
  2. mem_wen && !mem_load && mem_wsel == sel gives mem_wdat.
  3. wb_wen && wb_wsel == sel gives wb_wdat.
  4. Otherwise rdat.
- Hazard:
  - hazN = in_useN && selN != 0 && mem_wen && mem_load && mem_wsel == selN.
  - hazard = in_valid && (haz1 || haz2).
  - A MEM load to register 0 never causes a hazard.
- in_ready = flush || (!hazard && (!out_valid || ex_ready)).
- Registered update each rising edge, in priority order:
  1. flush: out_valid <= 0. Any incoming instruction is accepted and discarded. Data registers are held.
  2. in_valid && in_ready: out_valid <= 1; out_opa, out_opb, out_rd, out_ctrl <= selected and forwarded values.
  3. ex_ready: out_valid <= 0 (bubble, including during a hazard).
  4. Otherwise hold all registers.
- Latency: 1 cycle from acceptance to out_valid.
  - Throughput is 1 per cycle when ex_ready is held high and no hazard occurs.
  - While out_valid && !ex_ready, all outputs are stable.
- stall_cnt:
  - Increments by 1 on each edge where hazard && !flush.
  - Saturates at 2**CNT_W - 1 and does not wrap.
  - Never cleared except by reset.
- Reset (async, nRST low): out_valid = 0; out_opa, out_opb, out_ctrl, stall_cnt = 0; out_rd = 0. Reset takes effect immediately mid-operation; the first cycle after deassertion behaves as empty.
- Simultaneous events:
  - MEM and WB both match the same index: MEM value wins.
  - Hazard and flush together: flush wins, no stall is counted.
  - ex_ready while empty: no effect.

Test Plan:
- Reset with nRST=0 mid-stream while out_valid=1 -> out_valid=0, out_opa=0, stall_cnt=0 asynchronously, before the next clock edge.
- rs=3, rdat1=0x11, wb_wen=1, wb_wsel=3, wb_wdat=0xAA, in_valid=1, ex_ready=1 -> next cycle out_valid=1, out_opa=0xAA.
- rt=5, mem_wen=1, mem_load=0, mem_wsel=5, mem_wdat=0x55, and WB also targets 5 with 0x66 -> out_opb=0x55. With rt=0 and the same forwards -> out_opb=0.
- Load-use: mem_load=1, mem_wsel=7, in_rs=7, in_use1=1 for 2 cycles -> in_ready=0 both cycles, out_valid drops to 0 after ex_ready, stall_cnt=2. With in_use1=0 instead -> no stall.
- Backpressure: accept A with opa=0x1, hold ex_ready=0 for 3 cycles while in_valid stays high -> in_ready=0, out_opa holds 0x1. Raise ex_ready -> B captured next edge.
- flush=1 while out_valid=1 and in_valid=1 -> in_ready=1, next cycle out_valid=0. Separately, stall with CNT_W=2 for 5 hazard cycles -> stall_cnt saturates at 3.
